// File: rtl/deserializer_4bit_if.sv
// Handshake and data bundle between a serial source/consumer and deserializer_4bit.
// PAR_ERR is present only when PARITY_EN is defined.
`default_nettype none

interface deserializer_4bit_if;
    logic       S_IN;
    logic       S_EN;
    logic       START;
    logic       Q_READY;
    logic       CLR_OVR;
    logic [3:0] Q;
    logic       Q_VALID;
    logic       BUSY;
    logic       OVERRUN;
`ifdef PARITY_EN
    logic       PAR_ERR;
`endif

    // Stream source and word consumer side
    modport master (
        output S_IN, S_EN, START, Q_READY, CLR_OVR,
        input  Q, Q_VALID, BUSY, OVERRUN
`ifdef PARITY_EN
        , input PAR_ERR
`endif
    );

    // Deserializer side
    modport slave (
        input  S_IN, S_EN, START, Q_READY, CLR_OVR,
        output Q, Q_VALID, BUSY, OVERRUN
`ifdef PARITY_EN
        , output PAR_ERR
`endif
    );
endinterface

`default_nettype wire

// File: rtl/deserializer_4bit.sv
//==============================================================================
// Module   : deserializer_4bit
// Purpose  : Strobed serial-to-4-bit deserializer with START framing, a
//            one-word output holding register, sticky OVERRUN and optional
//            parity (macro PARITY_EN adds PAR state and PAR_ERR).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module deserializer_4bit #(
    parameter int MSB_FIRST = 1,
    parameter int PAR_ODD   = 0
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    deserializer_4bit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_SHIFT = 2'd1
    } state_t;

    state_t     state_q;
    logic [1:0] cnt_q;
    logic [3:0] sr_q;
    logic [3:0] q_q;
    logic       q_valid_q;
    logic       busy_q;
    logic       ovr_q;

    logic [3:0] w_first;
    logic [3:0] w_shifted;
    logic [3:0] w_word;
    logic       w_complete;
    logic       w_accept;

    // Where the first bit of a frame starts decides which end it finishes at
    assign w_first   = (MSB_FIRST != 0) ? {3'b000, bus.S_IN} : {bus.S_IN, 3'b000};
    assign w_shifted = (MSB_FIRST != 0) ? {sr_q[2:0], bus.S_IN} : {bus.S_IN, sr_q[3:1]};
    assign w_accept  = !q_valid_q || bus.Q_READY;

`ifdef PARITY_EN
    logic w_par_ok;
    logic w_par_fail;
    logic par_err_q;

    assign w_par_ok   = (((^sr_q) ^ bus.S_IN) == (PAR_ODD != 0));
    assign w_complete = (state_q == ST_PAR) && bus.S_EN && !bus.START && w_par_ok;
    assign w_par_fail = (state_q == ST_PAR) && bus.S_EN && !bus.START && !w_par_ok;
    assign w_word     = sr_q;
    assign bus.PAR_ERR = par_err_q;
`else
    logic w_unused_par_odd;

    assign w_unused_par_odd = (PAR_ODD != 0);
    assign w_complete = (state_q == ST_SHIFT) && bus.S_EN && !bus.START && (cnt_q == 2'd3);
    assign w_word     = w_shifted;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            sr_q      <= 4'b0000;
            q_q       <= 4'b0000;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            // A load on the same edge as a consume keeps Q_VALID high
            if (w_complete && w_accept) begin
                q_q       <= w_word;
                q_valid_q <= 1'b1;
            end else if (bus.Q_READY) begin
                q_valid_q <= 1'b0;
            end

            if (w_complete && !w_accept) begin
                ovr_q <= 1'b1;
            end else if (bus.CLR_OVR) begin
                ovr_q <= 1'b0;
            end
`ifdef PARITY_EN
            if (w_par_fail) begin
                par_err_q <= 1'b1;
            end else if (bus.CLR_OVR) begin
                par_err_q <= 1'b0;
            end
`endif

            if (bus.S_EN) begin
                if (bus.START) begin
                    // START always opens a fresh frame, aborting any partial one
                    sr_q    <= w_first;
                    cnt_q   <= 2'd1;
                    state_q <= ST_SHIFT;
                    busy_q  <= 1'b1;
                end else begin
                    case (state_q)
                        ST_SHIFT: begin
                            sr_q  <= w_shifted;
                            cnt_q <= cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
`ifdef PARITY_EN
                                state_q <= ST_PAR;
                                busy_q  <= 1'b1;
`else
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
`endif
                            end
                        end
`ifdef PARITY_EN
                        ST_PAR: begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
`endif
                        ST_IDLE: begin
                            state_q <= ST_IDLE;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.Q       = q_q;
    assign bus.Q_VALID = q_valid_q;
    assign bus.BUSY    = busy_q;
    assign bus.OVERRUN = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_deserializer_4bit.sv
// Directed bench for deserializer_4bit: an MSB-first and an LSB-first instance
// share one stimulus stream; each has its own expected-word queue.
`default_nettype none

module tb_deserializer_4bit;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    logic [3:0] qm[$];
    logic [3:0] ql[$];

    deserializer_4bit_if bus_m ();
    deserializer_4bit_if bus_l ();

    assign bus_l.S_IN    = bus_m.S_IN;
    assign bus_l.S_EN    = bus_m.S_EN;
    assign bus_l.START   = bus_m.START;
    assign bus_l.Q_READY = bus_m.Q_READY;
    assign bus_l.CLR_OVR = bus_m.CLR_OVR;

    deserializer_4bit #(.MSB_FIRST(1), .PAR_ODD(0)) dut_m (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_m)
    );

    deserializer_4bit #(.MSB_FIRST(0), .PAR_ODD(0)) dut_l (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_l)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards any word the DUTs loaded is matched against the queues
    task automatic tick;
        logic pv_m;
        logic pv_l;
        logic pr;
        logic [3:0] e;
        pv_m = bus_m.Q_VALID;
        pv_l = bus_l.Q_VALID;
        pr   = bus_m.Q_READY;
        @(posedge CLK);
        #1;
        if (bus_m.Q_VALID && (!pv_m || pr)) begin
            e = (qm.size() > 0) ? qm.pop_front() : 4'hx;
            chk("msb_word", bus_m.Q, e);
        end
        if (bus_l.Q_VALID && (!pv_l || pr)) begin
            e = (ql.size() > 0) ? ql.pop_front() : 4'hx;
            chk("lsb_word", bus_l.Q, e);
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        bus_m.S_EN  = 1'b1;
        bus_m.S_IN  = b;
        bus_m.START = st;
        tick();
        bus_m.S_EN  = 1'b0;
        bus_m.START = 1'b0;
    endtask

    // seq[3] is transmitted first
    task automatic send(input logic [3:0] seq, input logic rdy_last,
                        input logic clr_last, input logic push);
        if (push) begin
            qm.push_back(seq);
            ql.push_back({seq[0], seq[1], seq[2], seq[3]});
        end
        for (int i = 3; i >= 0; i--) begin
            bus_m.S_EN  = 1'b1;
            bus_m.S_IN  = seq[i];
            bus_m.START = (i == 3);
`ifndef PARITY_EN
            if (i == 0) begin
                bus_m.Q_READY = rdy_last;
                bus_m.CLR_OVR = clr_last;
            end
`endif
            tick();
            if (i == 3) chk("busy_in_frame", {3'b000, bus_m.BUSY}, 4'h1);
        end
`ifdef PARITY_EN
        bus_m.S_IN    = ^seq;
        bus_m.START   = 1'b0;
        bus_m.Q_READY = rdy_last;
        bus_m.CLR_OVR = clr_last;
        tick();
`endif
        bus_m.S_EN    = 1'b0;
        bus_m.START   = 1'b0;
        bus_m.Q_READY = 1'b0;
        bus_m.CLR_OVR = 1'b0;
    endtask

    task automatic consume;
        bus_m.Q_READY = 1'b1;
        tick();
        bus_m.Q_READY = 1'b0;
        chk("consume_valid", {3'b000, bus_m.Q_VALID}, 4'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Reset with strobe/START active must still leave everything cleared
        RESET         = 1'b1;
        bus_m.S_IN    = 1'b1;
        bus_m.S_EN    = 1'b1;
        bus_m.START   = 1'b1;
        bus_m.Q_READY = 1'b0;
        bus_m.CLR_OVR = 1'b0;
        tick();
        tick();
        chk("rst_q",       bus_m.Q, 4'h0);
        chk("rst_valid",   {3'b000, bus_m.Q_VALID}, 4'h0);
        chk("rst_busy",    {3'b000, bus_m.BUSY}, 4'h0);
        chk("rst_ovr",     {3'b000, bus_m.OVERRUN}, 4'h0);
        chk("rst_lsb_q",   bus_l.Q, 4'h0);
        bus_m.S_EN  = 1'b0;
        bus_m.START = 1'b0;
        RESET       = 1'b0;
        tick();

        // Bits 1,0,1,1: MSB-first 1011, LSB-first 1101
        send(4'b1011, 1'b0, 1'b0, 1'b1);
        chk("f1_valid", {3'b000, bus_m.Q_VALID}, 4'h1);
        chk("f1_busy",  {3'b000, bus_m.BUSY}, 4'h0);
        chk("f1_lsb_q", bus_l.Q, 4'b1101);
        consume();

        // Strobes without START in IDLE are ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("idle_ignore_busy", {3'b000, bus_m.BUSY}, 4'h0);

        // Overrun: A is held, 5 is dropped
        send(4'hA, 1'b0, 1'b0, 1'b1);
        send(4'h5, 1'b0, 1'b0, 1'b0);
        chk("ovr_q_held", bus_m.Q, 4'hA);
        chk("ovr_set",    {3'b000, bus_m.OVERRUN}, 4'h1);
        chk("ovr_set_l",  {3'b000, bus_l.OVERRUN}, 4'h1);
        bus_m.CLR_OVR = 1'b1;
        tick();
        bus_m.CLR_OVR = 1'b0;
        chk("ovr_clr", {3'b000, bus_m.OVERRUN}, 4'h0);

        // Ready on the completing edge: 3 replaces A, valid stays high
        send(4'h3, 1'b1, 1'b0, 1'b1);
        chk("swap_valid", {3'b000, bus_m.Q_VALID}, 4'h1);
        chk("swap_ovr",   {3'b000, bus_m.OVERRUN}, 4'h0);
        tick();
        chk("swap_hold",  bus_m.Q, 4'h3);
        consume();

        // START re-asserted at bit 2 aborts the partial frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        qm.push_back(4'b0110);
        ql.push_back(4'b0110);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
`ifdef PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        chk("abort_q", bus_m.Q, 4'b0110);
        consume();

        // Idle gaps between strobes hold the frame
        qm.push_back(4'b1001);
        ql.push_back(4'b1001);
        send_bit(1'b1, 1'b1);
        repeat (3) tick();
        chk("gap_busy", {3'b000, bus_m.BUSY}, 4'h1);
        send_bit(1'b0, 1'b0);
        tick();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
`ifdef PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        chk("gap_valid", {3'b000, bus_m.Q_VALID}, 4'h1);
        consume();

        // Reset mid-frame; following bits without START produce nothing
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_busy", {3'b000, bus_m.BUSY}, 4'h0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        chk("midrst_valid", {3'b000, bus_m.Q_VALID}, 4'h0);
        chk("midrst_busy2", {3'b000, bus_m.BUSY}, 4'h0);

        // Recovery frame, then overrun with CLR_OVR on the same edge (set wins)
        send(4'b0111, 1'b0, 1'b0, 1'b1);
        send(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("ovr2_set", {3'b000, bus_m.OVERRUN}, 4'h1);
        send(4'b0001, 1'b0, 1'b1, 1'b0);
        chk("ovr_set_wins", {3'b000, bus_m.OVERRUN}, 4'h1);
        chk("ovr2_q_held",  bus_m.Q, 4'b0111);
        bus_m.CLR_OVR = 1'b1;
        tick();
        bus_m.CLR_OVR = 1'b0;
        chk("ovr2_clr", {3'b000, bus_m.OVERRUN}, 4'h0);
        consume();

`ifdef PARITY_EN
        // Bits 1,1,1,0 with parity 0 under even parity: dropped, PAR_ERR set
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("par_err",   {3'b000, bus_m.PAR_ERR}, 4'h1);
        chk("par_valid", {3'b000, bus_m.Q_VALID}, 4'h0);
`endif

        chk("msb_queue_empty", qm.size() == 0 ? 4'h0 : 4'h1, 4'h0);
        chk("lsb_queue_empty", ql.size() == 0 ? 4'h0 : 4'h1, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/deserializer_4bit.md
DESERIALIZER_4BIT -- requirements
Module: deserializer_4bit

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in Q[3] and 0 = first bit lands in Q[0].
REQ-002 SHALL have parameter PAR_ODD, default 0, meaning 1 = odd parity and 0 = even parity; it is used only when PARITY_EN is defined.
REQ-003 SHALL have port CLK, input, 1 bit: the only clock, rising edge active.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port S_IN, input, 1 bit: serial data from the 4-bit shifting register's serial output.
REQ-006 SHALL have port S_EN, input, 1 bit: bit strobe; S_IN is sampled only on edges where S_EN=1.
REQ-007 SHALL have port START, input, 1 bit: marks the strobed bit as the first bit of a frame.
REQ-008 SHALL have port Q_READY, input, 1 bit: the consumer accepts Q.
REQ-009 SHALL have port CLR_OVR, input, 1 bit: clears OVERRUN.
REQ-010 SHALL have port Q, output, 4 bits: the received word.
REQ-011 SHALL have port Q_VALID, output, 1 bit: Q holds an unconsumed word.
REQ-012 SHALL have port BUSY, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port OVERRUN, output, 1 bit: sticky flag, a completed word was dropped.
REQ-014 SHALL have port PAR_ERR, output, 1 bit, present only when PARITY_EN is defined: sticky flag, a parity mismatch occurred.

Function
REQ-015 SHALL implement states IDLE, SHIFT and, when PARITY_EN is defined, PAR.
REQ-016 IDLE: S_EN=1 with START=1 SHALL capture bit 0 into the shift register, set the bit counter to 1 and go to SHIFT.
REQ-017 IDLE: S_EN=1 with START=0 SHALL be ignored.
REQ-018 SHIFT: each S_EN=1 edge SHALL capture one bit and increment the 2-bit bit counter.
REQ-019 SHIFT: edges with S_EN=0 SHALL hold all state, with no timeout.
REQ-020 SHIFT: the edge capturing the 4th bit SHALL complete the frame and go to IDLE, or to PAR if PARITY_EN is defined.
REQ-021 SHIFT: START=1 with S_EN=1 SHALL abort the current frame, treat the strobed bit as bit 0 of a new frame and reset the counter to 1.
REQ-022 The bit order within the captured word SHALL follow MSB_FIRST.
REQ-023 BUSY SHALL be 1 exactly while the state is not IDLE.
REQ-024 On frame completion, if Q_VALID=0 or Q_READY=1 in that cycle, the assembled word SHALL load into Q and Q_VALID SHALL be 1 on the next cycle (one-cycle latency after the last sample edge).
REQ-025 On frame completion with Q_VALID=1 and Q_READY=0, the new word SHALL be dropped, Q SHALL be unchanged and OVERRUN SHALL be set.
REQ-026 Q_VALID SHALL clear on an edge with Q_READY=1 unless a word loads on that same edge, in which case Q_VALID stays 1.
REQ-027 Q SHALL be stable while Q_VALID=1 and Q_READY=0.
REQ-028 CLR_OVR=1 SHALL clear OVERRUN; if an overrun occurs on the same edge, set wins.

Reset
REQ-029 With RESET=1 at an edge, the following SHALL become 0 regardless of other inputs: state (IDLE), bit counter, shift register, Q=4'b0000, Q_VALID, BUSY, OVERRUN and PAR_ERR.
REQ-030 RESET mid-frame SHALL discard partial data, and the next frame SHALL require START.
REQ-031 No output SHALL change asynchronously.

Configuration
REQ-032 Macro PARITY_EN defined: after the 4th bit the FSM SHALL enter PAR and the next S_EN=1 edge SHALL sample the parity bit.
REQ-033 PARITY_EN defined: on parity mismatch with PAR_ODD the word SHALL be dropped (no Q load) and PAR_ERR set, sticky until RESET or CLR_OVR.
REQ-034 PARITY_EN defined: on parity match the word SHALL be delivered per REQ-024/REQ-025, and START=1 in PAR SHALL abort as in REQ-021.
REQ-035 PARITY_EN undefined: the PAR state and the PAR_ERR port SHALL be absent, and frames SHALL be exactly 4 strobed bits.

Verification
REQ-036 MSB_FIRST=1, bits 1,0,1,1 on consecutive S_EN edges with START on the first -> Q=4'b1011, Q_VALID=1 one cycle after the 4th edge, BUSY=0.
REQ-037 MSB_FIRST=0, same bits -> Q=4'b1101.
REQ-038 Word 4'hA held with Q_READY=0, then frame 4'h5 completes -> Q stays 4'hA and OVERRUN=1; CLR_OVR pulse -> OVERRUN=0.
REQ-039 Q_READY=1 on the same edge a new frame 4'h3 completes while Q=4'hA is valid -> Q=4'h3 and Q_VALID stays 1.
REQ-040 START re-asserted at bit 2 of a frame, followed by bits 0,1,1,0 -> Q=4'b0110 and the aborted partial word is never seen.
REQ-041 RESET after 2 bits, then bits sent without START -> Q_VALID stays 0; with PARITY_EN and PAR_OD=0, bits 1,1,1,0 with parity 0 -> PAR_ERR=1 and Q_VALID=0.
